instr_exec: RTL
===============

# instr_exec

Execute stage directly downstream of the program-counter/ROM fetch block. It consumes the 8-bit instruction (`[7:5]` opcode, `[4:0]` operand) and applies it to an internal accumulator. It drives the fetch block's advance enable, so the PC moves only when an instruction retires. This lets multi-cycle operations such as the iterative multiply stall fetch.

## Interface
- `ACC_W`, default 8: accumulator width. Must be ≥ 5.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: global enable. While low, all state is frozen and `fetch_en` = 0.
- `instr_in`  in  8: instruction from the fetch stage (combinational from the current PC).
- `fetch_en`  out  1: advance request. Wired to the fetch stage's `ena`.
- `acc_out`  out  ACC_W: accumulator value.
- `zero_flag`  out  1: set when the accumulator result last written is 0.
- `carry_flag`  out  1: carry, borrow, or multiply overflow from the last writing op.
- `busy`  out  1: high while in state MUL.
- `instr_done`  out  1: one-cycle pulse in the cycle after an instruction retires.

## Operation
- Operand `imm` = `instr_in[4:0]`, zero-extended to `ACC_W`.
- Opcodes:
  - 000 ADD: `acc += imm`. Carry = bit `ACC_W` of the sum.
  - 001 SUB: `acc -= imm`. Carry = borrow (`acc < imm`).
  - 010 MUL: `acc *= imm`. Result truncated to `ACC_W`. Carry = OR of truncated product bits.
  - 011 AND, 100 OR, 101 XOR: bitwise with `imm`. Carry cleared.
  - 110 LDI: `acc = imm`. Carry cleared.
  - 111 NOP: no accumulator or flag change.
- Zero flag is updated on every op that writes `acc`, including AND/OR/XOR/LDI; NOP leaves it unchanged.
- States:
  - RUN
    - `ena`=1 and opcode ≠ MUL: execute in one edge. `fetch_en` = 1 combinationally in that cycle, so PC advances on the same edge.
    - `ena`=1 and opcode = MUL: latch multiplicand = `acc`, multiplier = `imm`. Clear product and step count. Go to MUL. `fetch_en` = 0.
  - MUL
    - Each enabled edge: if multiplier bit[count] = 1, add `multiplicand << count` into the product (width `ACC_W`+5). Then increment count.
    - In the cycle with count = 4, `fetch_en` = 1. On that edge, write the truncated product to `acc`, update flags, and return to RUN.
- `instr_in` is re-read only in RUN. During MUL it is ignored; it is stable anyway because PC does not advance.

## Timing
- Reset values: `acc_out` = 0, `zero_flag` = 0, `carry_flag` = 0, `busy` = 0, `instr_done` = 0, state = RUN, count = 0. `fetch_en` = 0 while `reset_n` = 0.
- Single-cycle op latency: result is visible on `acc_out` the cycle after the accepting edge.
- MUL timing: 1 latch edge + 5 step edges = 6 cycles from accept to retire.
  - `busy` is high for the 5 cycles after the latch edge.
- `fetch_en` is high in exactly one cycle per instruction: the retire cycle.
- `instr_done` rises on the retire edge and lasts one cycle.
- `ena` low mid-MUL: count, product and state hold; `fetch_en` = 0; the sequence resumes exactly where it stopped.
- Reset mid-MUL: immediate return to RUN. Partial product is discarded and `acc` is cleared.
- Wrap-around: ADD/SUB/MUL results are taken modulo 2^`ACC_W`. There is no saturation.

## Structure
- Shared package `jsilicon_isa_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_NOP`);
  - field positions (`OPC_MSB` = 7, `OPC_LSB` = 5, `IMM_W` = 5).
- The fetch stage must also use this package.
- Sub-module `seq_mul`: shift-add multiplier with `start`/`step`/`last` controls and a product output. `instr_exec` owns the FSM, accumulator and flags.

## Test plan
- ROM program ADD 3, SUB 2, MUL 5, NOP, `ena` held 1 after reset release:
  - `acc` = 3 after edge 1, then 1 after edge 2, then 5 after edge 8;
  - NOP retires on edge 9;
  - `fetch_en` is high on cycles 1, 2, 8, 9;
  - `busy` is high on cycles 4–8.
- LDI 1 then SUB 2 → `acc` = 0xFF, `carry_flag` = 1, `zero_flag` = 0.
- LDI 16, MUL 16, MUL 5 → 16×16 = 256 gives `acc` = 0x00, `zero_flag` = 1, `carry_flag` = 1. The following MUL 5 gives `acc` = 0, `carry_flag` = 0.
- Drop `ena` for 3 cycles during the 3rd MUL step: `acc`, `busy` and `fetch_en` hold. Result and retire are delayed by exactly 3 cycles.
- Assert `reset_n` = 0 asynchronously mid-MUL: outputs go to reset values without a clock edge. After release, the first instruction executes from RUN.
- LDI 0x1F, XOR 0x1F → `acc` = 0, `zero_flag` = 1, `carry_flag` = 0. A following NOP leaves all three unchanged.

Source files
------------

// File: rtl/jsilicon_isa_pkg.sv
// rtl/jsilicon_isa_pkg.sv - shared ISA fields, opcodes and execute-stage types
package jsilicon_isa_pkg;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_W   = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_MUL = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b100;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b101;
    localparam logic [OPC_W-1:0] OP_LDI = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOP = 3'b111;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } exec_state_e;

    function automatic logic [OPC_W-1:0] opc_of(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [IMM_W-1:0] imm_of(input logic [7:0] instr);
        return instr[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-add multiplier, one multiplier bit per step
module seq_mul
    import jsilicon_isa_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     step,
    input  logic [ACC_W-1:0]         multiplicand,
    input  logic [IMM_W-1:0]         multiplier,
    output logic                     last,
    output logic [ACC_W+IMM_W-1:0]   product
);

    localparam int PROD_W = ACC_W + IMM_W;

    logic [ACC_W-1:0]  mcand_q;
    logic [IMM_W-1:0]  mplier_q;
    logic [PROD_W-1:0] prod_q;
    logic [2:0]        count_q;
    logic [IMM_W-1:0]  mplier_sh;
    logic [PROD_W-1:0] partial;

    // product already includes the current step, so the final step's sum is usable on the retire edge
    always_comb begin
        mplier_sh = mplier_q >> count_q;
        partial   = mplier_sh[0] ? (PROD_W'(mcand_q) << count_q) : '0;
        product   = prod_q + partial;
    end

    assign last = (count_q == 3'(IMM_W - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
        end else if (start) begin
            mcand_q  <= multiplicand;
            mplier_q <= multiplier;
            prod_q   <= '0;
            count_q  <= '0;
        end else if (step) begin
            prod_q   <= product;
            count_q  <= last ? 3'd0 : count_q + 3'd1;
        end
    end

endmodule

// File: rtl/instr_exec.sv
// rtl/instr_exec.sv - accumulator execute stage that paces the fetch stage
module instr_exec
    import jsilicon_isa_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ena,
    input  logic [7:0]       instr_in,
    output logic             fetch_en,
    output logic [ACC_W-1:0] acc_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             busy,
    output logic             instr_done
);

    localparam int PROD_W = ACC_W + IMM_W;

    exec_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              done_q;
    logic              acc_wr;
    logic              mul_start, mul_step, mul_last;
    logic [PROD_W-1:0] mul_product;
    logic [OPC_W-1:0]  opcode;
    logic [ACC_W-1:0]  imm;
    logic [ACC_W:0]    sum, diff;

    assign opcode = opc_of(instr_in);
    assign imm    = ACC_W'(imm_of(instr_in));
    assign sum    = {1'b0, acc_q} + {1'b0, imm};
    assign diff   = {1'b0, acc_q} - {1'b0, imm};

    seq_mul #(.ACC_W(ACC_W)) u_mul (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (mul_start),
        .step         (mul_step),
        .multiplicand (acc_q),
        .multiplier   (imm_of(instr_in)),
        .last         (mul_last),
        .product      (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        acc_wr    = 1'b0;
        fetch_en  = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ena) begin
                    if (opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        fetch_en = 1'b1;
                        acc_wr   = (opcode != OP_NOP);
                        case (opcode)
                            OP_ADD: begin acc_d = sum[ACC_W-1:0];  carry_d = sum[ACC_W];  end
                            OP_SUB: begin acc_d = diff[ACC_W-1:0]; carry_d = acc_q < imm; end
                            OP_AND: begin acc_d = acc_q & imm;     carry_d = 1'b0;        end
                            OP_OR:  begin acc_d = acc_q | imm;     carry_d = 1'b0;        end
                            OP_XOR: begin acc_d = acc_q ^ imm;     carry_d = 1'b0;        end
                            OP_LDI: begin acc_d = imm;             carry_d = 1'b0;        end
                            default: ;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (ena) begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        fetch_en = 1'b1;
                        acc_wr   = 1'b1;
                        acc_d    = mul_product[ACC_W-1:0];
                        carry_d  = |mul_product[PROD_W-1:ACC_W];
                        state_d  = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
        zero_d = acc_wr ? (acc_d == '0) : zero_q;
        // the fetch stage may be out of reset earlier, so never advance it while we are held
        if (!reset_n) fetch_en = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= fetch_en;
        end
    end

    assign acc_out    = acc_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign busy       = (state_q == ST_MUL);
    assign instr_done = done_q;

endmodule
